// File: rtl/segment_frame_packer.sv
// Buffers combined segment words in a small FIFO and streams them out as frames of
// SEG_PER_FRAME data words followed by a 32-bit additive checksum word.
module segment_frame_packer #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned SEG_PER_FRAME = 8,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] seg_in,
  input  logic              seg_in_valid,
  output logic              seg_in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              out_is_csum,
  output logic [15:0]       frame_count,
  output logic              overflow_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(SEG_PER_FRAME + 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_WORD = CW'(SEG_PER_FRAME - 1);

  typedef enum logic {ST_DATA, ST_CSUM} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [DATA_W-1:0] acc;
  logic [CW-1:0]     word_cnt;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              load_en;
  logic              push;
  logic              pop;

  // Push is judged on the start-of-cycle count, so a full FIFO drops even when popped.
  always_comb begin
    fifo_full    = (count == FULL_CNT);
    fifo_empty   = (count == '0);
    fifo_head    = mem[rd_ptr];
    load_en      = !out_valid || out_ready;
    push         = seg_in_valid && !fifo_full;
    pop          = load_en && (state == ST_DATA) && !fifo_empty;
    seg_in_ready = !fifo_full;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_DATA;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      acc          <= '0;
      word_cnt     <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_is_csum  <= 1'b0;
      frame_count  <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= seg_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (seg_in_valid && fifo_full) begin
        overflow_err <= 1'b1;
      end
      if (out_valid && out_ready && out_is_csum) begin
        frame_count <= frame_count + 16'd1;
      end

      if (load_en) begin
        case (state)
          ST_DATA: begin
            if (!fifo_empty) begin
              out_data    <= fifo_head;
              out_valid   <= 1'b1;
              out_last    <= 1'b0;
              out_is_csum <= 1'b0;
              acc         <= acc + fifo_head;
              word_cnt    <= word_cnt + 1'b1;
              if (word_cnt == LAST_WORD) begin
                state <= ST_CSUM;
              end
            end else begin
              out_valid   <= 1'b0;
              out_last    <= 1'b0;
              out_is_csum <= 1'b0;
            end
          end
          ST_CSUM: begin
            out_data    <= acc;
            out_valid   <= 1'b1;
            out_last    <= 1'b1;
            out_is_csum <= 1'b1;
            acc         <= '0;
            word_cnt    <= '0;
            state       <= ST_DATA;
          end
          default: state <= ST_DATA;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_segment_frame_packer.sv
// Bench for segment_frame_packer: queue-based frame model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_segment_frame_packer;

  localparam int DW    = 32;
  localparam int SEG   = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] seg_in = '0;
  logic          seg_in_valid = 1'b0;
  logic          seg_in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic          out_is_csum;
  logic [15:0]   frame_count;
  logic          overflow_err;

  always #5 clk = ~clk;

  segment_frame_packer #(
    .DATA_W(DW),
    .SEG_PER_FRAME(SEG),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .seg_in(seg_in),
    .seg_in_valid(seg_in_valid),
    .seg_in_ready(seg_in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .out_is_csum(out_is_csum),
    .frame_count(frame_count),
    .overflow_err(overflow_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO contents and the current frame's emitted words as queues.
  logic [DW-1:0] m_fifo[$];
  logic [DW-1:0] m_frame[$];
  int            m_pos;
  logic          m_valid, m_last, m_csum, m_ovf;
  logic [DW-1:0] m_data;
  logic [15:0]   m_frames;
  bit            model_ok = 0;
  int            start_sz;
  bit            can_load;
  logic [DW-1:0] m_s;

  always @(posedge clk) begin
    if (reset) begin
      m_fifo.delete();
      m_frame.delete();
      m_pos    = 0;
      m_valid  = 1'b0;
      m_last   = 1'b0;
      m_csum   = 1'b0;
      m_ovf    = 1'b0;
      m_data   = '0;
      m_frames = '0;
      model_ok = 1;
    end else if (model_ok) begin
      start_sz = m_fifo.size();
      can_load = !m_valid || out_ready;
      if (m_valid && out_ready && m_csum) m_frames++;
      if (seg_in_valid && start_sz == DEPTH) m_ovf = 1'b1;
      if (can_load) begin
        if (m_pos == SEG) begin
          m_s = '0;
          foreach (m_frame[i]) m_s += m_frame[i];
          m_data  = m_s;
          m_valid = 1'b1;
          m_last  = 1'b1;
          m_csum  = 1'b1;
          m_frame.delete();
          m_pos = 0;
        end else if (start_sz > 0) begin
          m_data  = m_fifo.pop_front();
          m_valid = 1'b1;
          m_last  = 1'b0;
          m_csum  = 1'b0;
          m_frame.push_back(m_data);
          m_pos++;
        end else begin
          m_valid = 1'b0;
          m_last  = 1'b0;
          m_csum  = 1'b0;
        end
      end
      if (seg_in_valid && start_sz < DEPTH) m_fifo.push_back(seg_in);
    end
  end

  logic [DW-1:0] hs_data[$];
  logic          hs_last[$];

  always @(negedge clk) begin
    if (model_ok) begin
      chk("out_valid", out_valid, m_valid);
      chk("seg_in_ready", seg_in_ready, m_fifo.size() != DEPTH);
      chk("frame_count", frame_count, m_frames);
      chk("overflow_err", overflow_err, m_ovf);
      if (m_valid) begin
        chk("out_data", out_data, m_data);
        chk("out_last", out_last, m_last);
        chk("out_is_csum", out_is_csum, m_csum);
      end
      if (out_valid === 1'b1 && out_ready) begin
        hs_data.push_back(out_data);
        hs_last.push_back(out_last);
      end
    end
  end

  logic [DW-1:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    seg_in_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    seg_in = w;
    seg_in_valid = 1'b1;
    tick();
    seg_in_valid = 1'b0;
  endtask

  task automatic clear_log();
    hs_data.delete();
    hs_last.delete();
  endtask

  task automatic check_reset_state();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_is_csum", out_is_csum, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_overflow_err", overflow_err, 0);
    chk("rst_seg_in_ready", seg_in_ready, 1);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, hs_data.size(), exp_q.size());
    for (int unsigned i = 0; i < exp_q.size() && i < hs_data.size(); i++) begin
      chk({tag, "_data"}, hs_data[i], exp_q[i]);
      chk({tag, "_last"}, hs_last[i], i == exp_q.size() - 1);
    end
  endtask

  initial begin
    idle(2);

    // Basic frame 1..8, checksum 36
    do_reset();
    check_reset_state();
    clear_log();
    out_ready = 1'b1;
    for (int unsigned i = 1; i <= 8; i++) push_word(DW'(i));
    idle(6);
    exp_q.delete();
    for (int unsigned i = 1; i <= 8; i++) exp_q.push_back(DW'(i));
    exp_q.push_back(32'h24);
    check_log("basic");
    chk("basic_frame_count", frame_count, 1);
    chk("basic_overflow", overflow_err, 0);

    // Checksum wrap and two-edge latency
    do_reset();
    clear_log();
    seg_in = 32'hFFFF_FFFF;
    seg_in_valid = 1'b1;
    tick();
    chk("lat_edge1_valid", out_valid, 0);
    tick();
    chk("lat_edge2_valid", out_valid, 1);
    chk("lat_edge2_data", out_data, 32'hFFFF_FFFF);
    idle(6);
    seg_in_valid = 1'b0;
    idle(6);
    exp_q.delete();
    repeat (8) exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'hFFFF_FFF8);
    check_log("wrap");
    chk("wrap_frame_count", frame_count, 1);

    // Back-pressure hold
    do_reset();
    out_ready = 1'b0;
    repeat (5) push_word(32'hA5A5_A5A5);
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 32'hA5A5_A5A5);
    chk("bp_ready", seg_in_ready, 0);
    chk("bp_overflow", overflow_err, 0);
    idle(3);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_data", out_data, 32'hA5A5_A5A5);
    out_ready = 1'b1;

    // Overflow: sixth word dropped
    do_reset();
    clear_log();
    out_ready = 1'b0;
    for (int unsigned i = 1; i <= 6; i++) push_word(DW'(i));
    chk("ovf_flag", overflow_err, 1);
    chk("ovf_ready", seg_in_ready, 0);
    out_ready = 1'b1;
    idle(2);
    chk("ovf_sticky", overflow_err, 1);
    for (int unsigned i = 7; i <= 9; i++) push_word(DW'(i));
    idle(8);
    exp_q.delete();
    for (int unsigned i = 1; i <= 5; i++) exp_q.push_back(DW'(i));
    for (int unsigned i = 7; i <= 9; i++) exp_q.push_back(DW'(i));
    exp_q.push_back(32'd39);
    check_log("ovf");
    chk("ovf_sticky_end", overflow_err, 1);

    // Simultaneous push and pop on a full FIFO
    do_reset();
    out_ready = 1'b0;
    for (int unsigned i = 11; i <= 15; i++) push_word(DW'(i));
    seg_in = 32'd16;
    seg_in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    seg_in_valid = 1'b0;
    out_ready = 1'b0;
    chk("pp_overflow", overflow_err, 1);
    chk("pp_ready_after", seg_in_ready, 1);
    chk("pp_data", out_data, 32'd12);
    push_word(32'd17);
    chk("pp_refill_ready", seg_in_ready, 0);
    out_ready = 1'b1;

    // Reset mid-frame
    do_reset();
    for (int unsigned i = 1; i <= 3; i++) push_word(DW'(i));
    do_reset();
    check_reset_state();
    clear_log();
    for (int unsigned i = 10; i <= 17; i++) push_word(DW'(i));
    idle(6);
    exp_q.delete();
    for (int unsigned i = 10; i <= 17; i++) exp_q.push_back(DW'(i));
    exp_q.push_back(32'h6C);
    check_log("midrst");
    chk("midrst_frame_count", frame_count, 1);

    // Randomized traffic against the model
    do_reset();
    for (int unsigned n = 0; n < 4000; n++) begin
      seg_in       = $urandom;
      seg_in_valid = ($urandom_range(0, 9) < 7);
      out_ready    = ($urandom_range(0, 9) < ((n / 500) % 2 == 0 ? 8 : 5));
      reset        = ($urandom_range(0, 799) == 0);
      tick();
    end
    reset = 1'b0;
    seg_in_valid = 1'b0;
    out_ready = 1'b1;
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
